// File: rtl/rv32imf_apu_core_pkg.sv
// +----------------------------------------------------------------------+
// | rv32imf_apu_core_pkg: shared types for the APU dispatch path.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32imf_apu_core_pkg;

    localparam int APU_DISP_DEPTH  = 4;
    localparam int APU_DISP_ADDR_W = 6;

    typedef enum logic [1:0] {
        LAT_ADDMUL  = 2'd0,
        LAT_DIVSQRT = 2'd1,
        LAT_NONCOMP = 2'd2,
        LAT_CONV    = 2'd3
    } lat_class_e;

    typedef struct packed {
        logic [APU_DISP_ADDR_W-1:0] waddr;
        lat_class_e                 lat_class;
    } apu_disp_entry_t;

endpackage

`default_nettype wire

// File: rtl/rv32imf_apu_disp_fifo.sv
// +----------------------------------------------------------------------+
// | rv32imf_apu_disp_fifo: in-order pointer FIFO exposing every entry.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rv32imf_apu_disp_fifo #(
    parameter int DEPTH = 4,
    parameter int ENT_W = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [ENT_W-1:0]              push_data_i,
    output logic [ENT_W-1:0]              head_o,
    output logic [DEPTH-1:0][ENT_W-1:0]   entries_o,
    output logic [DEPTH-1:0]              valid_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) mem_q[tail_q] <= push_data_i;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PTR_W-1:0] w_off;
        assign w_off      = PTR_W'(i) - head_q;
        assign valid_o[i] = ({1'b0, w_off} < count_q);
    end

    assign head_o    = mem_q[head_q];
    assign entries_o = mem_q;
    assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/rv32imf_apu_disp.sv
// +----------------------------------------------------------------------+
// | rv32imf_apu_disp: hazard/class-gated APU dispatch with WB pairing.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rv32imf_apu_disp
    import rv32imf_apu_core_pkg::*;
#(
    parameter int DEPTH  = APU_DISP_DEPTH,
    parameter int ADDR_W = APU_DISP_ADDR_W,
    parameter int LAT_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [LAT_W-1:0]    lat_class_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [3*ADDR_W-1:0] raddr_i,
    input  logic [2:0]          raddr_valid_i,
    output logic                ready_o,
    output logic                apu_req_o,
    input  logic                apu_gnt_i,
    input  logic                apu_rvalid_i,
    output logic                wb_valid_o,
    output logic [ADDR_W-1:0]   wb_waddr_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + LAT_W;

    logic [ENT_W-1:0]            head;
    logic [DEPTH-1:0][ENT_W-1:0] entries;
    logic [DEPTH-1:0]            entry_valid;
    logic [CNT_W-1:0]            count;
    logic [LAT_W-1:0]            last_class_q;
    logic                        err_q;
    logic                        hazard, full, class_conflict, blocked, pop, nonempty;
    logic [(DEPTH+1)*LAT_W-1:0]  unused_lat;

    rv32imf_apu_disp_fifo #(
        .DEPTH (DEPTH),
        .ENT_W (ENT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ready_o),
        .pop_i       (pop),
        .push_data_i ({waddr_i, lat_class_i}),
        .head_o      (head),
        .entries_o   (entries),
        .valid_o     (entry_valid),
        .count_o     (count)
    );

    // RAW on any valid source or WAW on the destination against every live entry.
    always_comb begin
        hazard     = 1'b0;
        unused_lat = {head[LAT_W-1:0], {(DEPTH*LAT_W){1'b0}}};
        for (int i = 0; i < DEPTH; i++) begin
            unused_lat[i*LAT_W +: LAT_W] = entries[i][LAT_W-1:0];
            if (entry_valid[i]) begin
                if (entries[i][ENT_W-1:LAT_W] == waddr_i) hazard = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    if (raddr_valid_i[k] &&
                        entries[i][ENT_W-1:LAT_W] == raddr_i[k*ADDR_W +: ADDR_W])
                        hazard = 1'b1;
                end
            end
        end
    end

    assign nonempty       = (count != '0);
    assign full           = (count == CNT_W'(DEPTH));
    assign class_conflict = nonempty && (lat_class_i != last_class_q);
    assign blocked        = full | hazard | class_conflict;

    assign apu_req_o  = req_i & ~blocked;
    assign ready_o    = apu_req_o & apu_gnt_i;
    assign pop        = apu_rvalid_i & nonempty;
    assign wb_valid_o = pop;
    assign wb_waddr_o = pop ? head[ENT_W-1:LAT_W] : '0;
    assign busy_o     = nonempty;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_class_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (ready_o) last_class_q <= lat_class_i;
            if (apu_rvalid_i && !nonempty) err_q <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32imf_apu_disp.sv
// +----------------------------------------------------------------------+
// | tb_rv32imf_apu_disp: directed + random bench with queue-based model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rv32imf_apu_disp;
    import rv32imf_apu_core_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [1:0]  lat_class_i;
    logic [5:0]  waddr_i;
    logic [17:0] raddr_i;
    logic [2:0]  raddr_valid_i;
    logic        ready_o, apu_req_o, apu_gnt_i, apu_rvalid_i;
    logic        wb_valid_o, busy_o, err_o;
    logic [5:0]  wb_waddr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] waddr;
        logic [1:0] cls;
    } ent_t;

    ent_t       mq[$];
    logic [1:0] m_last = 2'd0;
    bit         m_err  = 1'b0;

    always #5 clk_i = ~clk_i;

    rv32imf_apu_disp #(.DEPTH(DEPTH), .ADDR_W(6), .LAT_W(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .lat_class_i   (lat_class_i),
        .waddr_i       (waddr_i),
        .raddr_i       (raddr_i),
        .raddr_valid_i (raddr_valid_i),
        .ready_o       (ready_o),
        .apu_req_o     (apu_req_o),
        .apu_gnt_i     (apu_gnt_i),
        .apu_rvalid_i  (apu_rvalid_i),
        .wb_valid_o    (wb_valid_o),
        .wb_waddr_o    (wb_waddr_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs against the model, clock, update model.
    task automatic cyc(input bit req, input logic [1:0] cls, input logic [5:0] wa,
                       input logic [17:0] ra, input logic [2:0] rv,
                       input bit gnt, input bit rvalid, input string tag);
        bit         haz, blk, e_req, e_rdy, e_wbv;
        logic [5:0] e_wa;
        req_i = req; lat_class_i = cls; waddr_i = wa; raddr_i = ra;
        raddr_valid_i = rv; apu_gnt_i = gnt; apu_rvalid_i = rvalid;
        #1;
        haz = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].waddr == wa) haz = 1'b1;
            for (int k = 0; k < 3; k++)
                if (rv[k] && ra[k*6 +: 6] == mq[i].waddr) haz = 1'b1;
        end
        blk   = (mq.size() == DEPTH) || haz || (mq.size() != 0 && cls != m_last);
        e_req = req && !blk;
        e_rdy = e_req && gnt;
        e_wbv = rvalid && mq.size() != 0;
        e_wa  = e_wbv ? mq[0].waddr : 6'd0;
        chk({tag, ".apu_req"}, {31'd0, apu_req_o}, {31'd0, e_req});
        chk({tag, ".ready"},   {31'd0, ready_o},   {31'd0, e_rdy});
        chk({tag, ".wb_valid"},{31'd0, wb_valid_o},{31'd0, e_wbv});
        chk({tag, ".wb_waddr"},{26'd0, wb_waddr_o},{26'd0, e_wa});
        chk({tag, ".busy"},    {31'd0, busy_o},    {31'd0, bit'(mq.size() != 0)});
        chk({tag, ".err"},     {31'd0, err_o},     {31'd0, m_err});
        @(posedge clk_i);
        if (rvalid && mq.size() == 0) m_err = 1'b1;
        if (e_wbv) void'(mq.pop_front());
        if (e_rdy) begin
            mq.push_back('{waddr: wa, cls: cls});
            m_last = cls;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(0, 2'd0, 6'd0, 18'd0, 3'b000, 0, 0, tag);
    endtask

    task automatic rv_only(input string tag);
        cyc(0, 2'd0, 6'd0, 18'd0, 3'b000, 0, 1, tag);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 0; lat_class_i = 0; waddr_i = 0; raddr_i = 0;
        raddr_valid_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0;
        #12;
        chk("rst.busy",     {31'd0, busy_o},     32'd0);
        chk("rst.err",      {31'd0, err_o},      32'd0);
        chk("rst.wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst.wb_waddr", {26'd0, wb_waddr_o}, 32'd0);
        chk("rst.apu_req",  {31'd0, apu_req_o},  32'd0);
        @(posedge clk_i); #1; rst_i = 1'b0;

        // Single op, writeback 3 cycles later
        cyc(1, LAT_ADDMUL, 6'd5, 18'd0, 3'b000, 1, 0, "t1.push");
        chk("t1.busy_next", {31'd0, busy_o}, 32'd1);
        idle("t1.w1"); idle("t1.w2");
        req_i = 0; apu_rvalid_i = 1; #1;
        chk("t1.wb_waddr5", {26'd0, wb_waddr_o}, 32'd5);
        cyc(0, 2'd0, 6'd0, 18'd0, 3'b000, 0, 1, "t1.rv");
        chk("t1.busy_after", {31'd0, busy_o}, 32'd0);

        // Fill, full blocking, simultaneous pop, ordered drain
        for (int i = 1; i <= 4; i++)
            cyc(1, LAT_ADDMUL, 6'(i), 18'd0, 3'b000, 1, 0, "t2.fill");
        cyc(1, LAT_ADDMUL, 6'd9, 18'd0, 3'b000, 1, 0, "t2.full");
        cyc(1, LAT_ADDMUL, 6'd9, 18'd0, 3'b000, 1, 1, "t2.full_pop");
        cyc(1, LAT_ADDMUL, 6'd9, 18'd0, 3'b000, 1, 0, "t2.after_pop");
        for (int i = 0; i < 4; i++) rv_only("t2.drain");

        // RAW hazard on valid source vs. same address on invalid source
        cyc(1, LAT_ADDMUL, 6'd7, 18'd0, 3'b000, 1, 0, "t3.r7");
        cyc(1, LAT_ADDMUL, 6'd8, {6'd0, 6'd7, 6'd0}, 3'b010, 1, 0, "t3.raw");
        cyc(1, LAT_ADDMUL, 6'd8, {6'd0, 6'd7, 6'd0}, 3'b101, 0, 0, "t3.inv");
        cyc(1, LAT_ADDMUL, 6'd8, {6'd0, 6'd7, 6'd0}, 3'b010, 1, 1, "t3.rv");
        cyc(1, LAT_ADDMUL, 6'd8, {6'd0, 6'd7, 6'd0}, 3'b010, 1, 0, "t3.go");
        rv_only("t3.drain");

        // Class switch waits for drain; new class then locks out the old one
        cyc(1, LAT_ADDMUL,  6'd10, 18'd0, 3'b000, 1, 0, "t4.add");
        cyc(1, LAT_DIVSQRT, 6'd11, 18'd0, 3'b000, 1, 0, "t4.blk");
        cyc(1, LAT_DIVSQRT, 6'd11, 18'd0, 3'b000, 1, 1, "t4.rv");
        cyc(1, LAT_DIVSQRT, 6'd11, 18'd0, 3'b000, 1, 0, "t4.div");
        cyc(1, LAT_ADDMUL,  6'd12, 18'd0, 3'b000, 1, 0, "t4.add_blk");
        rv_only("t4.drain");

        // Grant withheld for 5 cycles
        for (int i = 0; i < 5; i++)
            cyc(1, LAT_CONV, 6'd20, 18'd0, 3'b000, 0, 0, "t5.nognt");
        chk("t5.no_push", {31'd0, busy_o}, 32'd0);
        cyc(1, LAT_CONV, 6'd20, 18'd0, 3'b000, 1, 0, "t5.gnt");
        cyc(1, LAT_CONV, 6'd21, 18'd0, 3'b000, 0, 0, "t5.one");
        rv_only("t5.drain");
        idle("t5.empty");

        // Spurious rvalid, then async reset with two ops in flight
        rv_only("t6.spur");
        chk("t6.err", {31'd0, err_o}, 32'd1);
        cyc(1, LAT_NONCOMP, 6'd30, 18'd0, 3'b000, 1, 0, "t6.p1");
        cyc(1, LAT_NONCOMP, 6'd31, 18'd0, 3'b000, 1, 0, "t6.p2");
        req_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0;
        #2 rst_i = 1'b1; #1;
        chk("t6.arst_busy", {31'd0, busy_o}, 32'd0);
        chk("t6.arst_err",  {31'd0, err_o},  32'd0);
        mq.delete(); m_err = 1'b0; m_last = 2'd0;
        @(posedge clk_i); #2 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic [17:0] ra;
            ra = {3'd0, 3'($urandom_range(7)), 3'd0, 3'($urandom_range(7)),
                  3'd0, 3'($urandom_range(7))};
            cyc(bit'($urandom_range(3) != 0), 2'($urandom_range(3) == 0),
                6'($urandom_range(7)), ra, 3'($urandom_range(7)),
                bit'($urandom_range(2) != 0),
                (mq.size() != 0) ? bit'($urandom_range(2) == 0) : bit'($urandom_range(40) == 0),
                "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
